// File: rtl/cbfp_denorm.sv
// rtl/cbfp_denorm.sv - CBFP denormalizer: two-stage pipelined per-sample shift with block index check.
// Define CBFP_DENORM_SAT_EN to clamp out-of-range results instead of wrapping.
module cbfp_denorm #(
  parameter int IN_W      = 13,
  parameter int OUT_W     = 16,
  parameter int IDX_W     = 6,
  parameter int BIAS      = 9,
  parameter int N         = 512,
  parameter int BLOCK_LEN = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_re,
  input  logic signed [IN_W-1:0]  in_im,
  input  logic [IDX_W-1:0]        in_idx0,
  input  logic [IDX_W-1:0]        in_idx1,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_re,
  output logic signed [OUT_W-1:0] out_im,
  output logic                    out_last,
  output logic                    blk_err
);

  localparam int TW = IDX_W + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [TW-1:0] BIAS_T   = TW'(BIAS);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLOCK_LEN - 1);

`ifdef CBFP_DENORM_SAT_EN
  // Wide enough to hold the largest left shift plus a guard bit for range detection.
  localparam int WW = ((IN_W + BIAS > OUT_W) ? IN_W + BIAS : OUT_W) + 1;
  localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [WW-1:0]    W_MAX   = WW'(OUT_MAX);
  localparam logic signed [WW-1:0]    W_MIN   = WW'(OUT_MIN);
`else
  // Working at OUT_W directly gives two's complement wrap for free.
  localparam int WW = OUT_W;
`endif

  function automatic logic signed [OUT_W-1:0] denorm(input logic signed [IN_W-1:0] x,
                                                     input logic [TW-1:0] t);
    logic signed [WW-1:0] w;
    w = {{(WW-IN_W){x[IN_W-1]}}, x};
    if (t >= BIAS_T) w = w >>> (t - BIAS_T);
    else             w = w <<< (BIAS_T - t);
`ifdef CBFP_DENORM_SAT_EN
    if (w > W_MAX)      return OUT_MAX;
    else if (w < W_MIN) return OUT_MIN;
    else                return w[OUT_W-1:0];
`else
    return w;
`endif
  endfunction

  logic                   s1_full;
  logic signed [IN_W-1:0] s1_re;
  logic signed [IN_W-1:0] s1_im;
  logic [TW-1:0]          s1_t;
  logic                   s1_last;
  logic [CW-1:0]          sample_cnt;
  logic [BW-1:0]          blk_cnt;
  logic [IDX_W-1:0]       ref0;
  logic [IDX_W-1:0]       ref1;
  logic                   s1_adv;
  logic                   in_xfer;

  assign s1_adv   = s1_full && (!out_valid || out_ready);
  assign in_ready = !s1_full || s1_adv;
  assign in_xfer  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_full    <= 1'b0;
      s1_re      <= '0;
      s1_im      <= '0;
      s1_t       <= '0;
      s1_last    <= 1'b0;
      out_valid  <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      out_last   <= 1'b0;
      blk_err    <= 1'b0;
      sample_cnt <= '0;
      blk_cnt    <= '0;
      ref0       <= '0;
      ref1       <= '0;
    end else begin
      if (in_xfer) begin
        s1_re      <= in_re;
        s1_im      <= in_im;
        s1_t       <= TW'(in_idx0) + TW'(in_idx1);
        s1_last    <= (sample_cnt == LAST_CNT);
        sample_cnt <= (sample_cnt == LAST_CNT) ? '0 : sample_cnt + 1'b1;
        blk_cnt    <= (blk_cnt == BLK_LAST || sample_cnt == LAST_CNT) ? '0 : blk_cnt + 1'b1;
        if (blk_cnt == '0) begin
          ref0 <= in_idx0;
          ref1 <= in_idx1;
        end else if (in_idx0 != ref0 || in_idx1 != ref1) begin
          blk_err <= 1'b1;
        end
      end

      if (in_xfer)     s1_full <= 1'b1;
      else if (s1_adv) s1_full <= 1'b0;

      // Output registers only change when a new sample moves in, so they hold under backpressure.
      if (s1_adv) begin
        out_valid <= 1'b1;
        out_re    <= denorm(s1_re, s1_t);
        out_im    <= denorm(s1_im, s1_t);
        out_last  <= s1_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cbfp_denorm.sv
// tb/tb_cbfp_denorm.sv - directed table-driven bench for cbfp_denorm.
module tb_cbfp_denorm;
  localparam int IN_W  = 13;
  localparam int OUT_W = 16;
  localparam int IDX_W = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_re;
  logic signed [IN_W-1:0]  in_im;
  logic [IDX_W-1:0]        in_idx0;
  logic [IDX_W-1:0]        in_idx1;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_re;
  logic signed [OUT_W-1:0] out_im;
  logic                    out_last;
  logic                    blk_err;

  cbfp_denorm dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_idx0(in_idx0), .in_idx1(in_idx1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_last(out_last),
    .blk_err(blk_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int re, im, i0, i1, ere, eim;
  } vec_t;
  vec_t vt[10];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic stream(input int n, input bit toggle, input string tag, output int cyc);
    int sent;
    int got;
    sent = 0;
    got = 0;
    cyc = 0;
    in_idx0 = 6'd4;
    in_idx1 = 6'd5;
    while (got < n && cyc < 8 * n + 50) begin
      in_valid  = (sent < n);
      in_re     = IN_W'(sent);
      in_im     = IN_W'(-sent);
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (out_re !== OUT_W'(got) || out_im !== OUT_W'(-got) || out_last !== (got % 512 == 511)) begin
          errors++;
          $display("FAIL %s out#%0d: got re=%0d im=%0d last=%0b expected re=%0d im=%0d last=%0b",
                   tag, got, out_re, out_im, out_last, got, -got, (got % 512 == 511));
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk({tag, " count"}, got, n);
  endtask

  initial begin
    int cyc;
    vt[0] = '{100, -100, 4, 5, 100, -100};
    vt[1] = '{-7, 5, 6, 6, -1, 0};
    vt[2] = '{3, -3, 2, 3, 48, -48};
`ifdef CBFP_DENORM_SAT_EN
    vt[3] = '{4095, -4096, 0, 0, 32767, -32768};
    vt[9] = '{255, 256, 0, 1, 32767, 32767};
`else
    vt[3] = '{4095, -4096, 0, 0, -512, 0};
    vt[9] = '{255, 256, 0, 1, -256, 0};
`endif
    vt[4] = '{-4096, 1, 63, 63, -1, 0};
    vt[5] = '{1000, -1000, 9, 0, 1000, -1000};
    vt[6] = '{64, -64, 2, 0, 8192, -8192};
    vt[7] = '{-9, 9, 5, 6, -3, 2};
    vt[8] = '{-1, 1, 10, 9, -1, 0};

    rst = 1'b1;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    in_idx0 = '0;
    in_idx1 = '0;
    out_ready = 1'b1;
    do_reset();
    chk("reset out_valid", out_valid, 0);
    chk("reset out_re", out_re, 0);
    chk("reset out_im", out_im, 0);
    chk("reset out_last", out_last, 0);
    chk("reset blk_err", blk_err, 0);
    chk("reset in_ready", in_ready, 1);

    // Single samples: 1 cycle after transfer still empty, valid exactly 2 cycles after.
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_re    = IN_W'(vt[k].re);
      in_im    = IN_W'(vt[k].im);
      in_idx0  = IDX_W'(vt[k].i0);
      in_idx1  = IDX_W'(vt[k].i1);
      #1;
      chk($sformatf("vec%0d in_ready", k), in_ready, 1);
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d early valid", k), out_valid, 0);
      step();
      chk($sformatf("vec%0d out_valid", k), out_valid, 1);
      chk($sformatf("vec%0d out_re", k), out_re, vt[k].ere);
      chk($sformatf("vec%0d out_im", k), out_im, vt[k].eim);
      step();
    end

    // Backpressure hold.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_re = 13'sd77;
    in_im = -13'sd77;
    in_idx0 = 6'd4;
    in_idx1 = 6'd5;
    step();
    in_valid = 1'b0;
    step();
    chk("hold valid0", out_valid, 1);
    chk("hold re0", out_re, 77);
    step();
    step();
    step();
    chk("hold valid1", out_valid, 1);
    chk("hold re1", out_re, 77);
    chk("hold im1", out_im, -77);
    out_ready = 1'b1;
    step();
    chk("hold drained", out_valid, 0);

    // 1024 samples with toggling out_ready.
    do_reset();
    stream(1024, 1'b1, "toggle", cyc);
    chk("no blk_err on steady idx", blk_err, 0);

    // Block index change at sample 63.
    do_reset();
    out_ready = 1'b1;
    for (int s = 0; s < 512; s++) begin
      in_valid = 1'b1;
      in_re = IN_W'(s);
      in_im = '0;
      in_idx0 = 6'd3;
      in_idx1 = (s == 63) ? 6'd4 : 6'd3;
      step();
      if (s == 62) chk("blk_err before change", blk_err, 0);
      if (s == 64) chk("blk_err after change", blk_err, 1);
    end
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("blk_err at frame end", blk_err, 1);
    do_reset();
    chk("blk_err cleared", blk_err, 0);

    // Reset mid-frame after 200 samples, then full-rate frame.
    out_ready = 1'b1;
    in_idx0 = 6'd4;
    in_idx1 = 6'd5;
    for (int s = 0; s < 200; s++) begin
      in_valid = 1'b1;
      in_re = IN_W'(s + 5);
      in_im = '0;
      step();
    end
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    chk("midreset out_valid", out_valid, 0);
    chk("midreset out_re", out_re, 0);
    chk("midreset out_last", out_last, 0);
    rst = 1'b0;
    #1;
    chk("midreset in_ready", in_ready, 1);
    stream(512, 1'b0, "fullrate", cyc);
    chk("fullrate cycles", (cyc <= 515), 1);
    step();
    step();
    chk("no extra output", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
